// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM encoding, memory command
// payload and byte-lane helpers.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Anything that is not a byte or halfword opcode is treated as a word access.
    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: access_size = SZ_HALF;
            default:              access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_be = 4'b0001 << lane;
            SZ_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: lane_wdata = {4{data[7:0]}};
            SZ_HALF: lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extender.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extender
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [5:0]  op_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata_i[{lane_i, 3'b000} +: 8];
        half_c = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            OP_LB:   ext_o = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  ext_o = {24'd0, byte_c};
            OP_LH:   ext_o = {{16{half_c[15]}}, half_c};
            OP_LHU:  ext_o = {16'd0, half_c};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: launches req/ack memory transactions for loads/stores,
// stalls the pipe while one is outstanding and feeds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadIN,
    input  logic        MemWriteIN,
    input  logic        MemtoRegIN,
    input  logic        RegWriteIN,
    input  logic [31:0] ALU_IN,
    input  logic [31:0] readData2IN,
    input  logic [4:0]  DestinoIN,
    input  logic [5:0]  tipoLoadIN,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        RegWriteOUT,
    output logic        MemtoRegOUT,
    output logic [31:0] ReadDataOUT,
    output logic [31:0] ALU_OUT,
    output logic [4:0]  DestinoOUT,
    output logic        addr_err,
    output logic        bus_err
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    mem_cmd_t    cmd_q, cmd_c, in_cmd;
    logic [31:0] alu_q, rdata_q, ext_c;
    logic [5:0]  op_q;
    logic [4:0]  dest_q;
    logic        regwr_q, m2r_q;

    logic        in_access, in_mis;
    logic [1:0]  in_size;
    logic        req_c, stall_c, cap_c, ack_cap_c, wb_load_c;
    logic [29:0] addr_c;

    logic        wb_regwr_q, wb_regwr_d, wb_m2r_q, wb_m2r_d;
    logic [31:0] wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        addr_err_q, addr_err_d, bus_err_q, bus_err_d;

    always_comb begin
        in_access    = MemReadIN | MemWriteIN;
        in_size      = access_size(tipoLoadIN);
        in_mis       = misaligned(in_size, ALU_IN[1:0]);
        in_cmd.we    = MemWriteIN;
        in_cmd.be    = lane_be(in_size, ALU_IN[1:0]);
        in_cmd.wdata = lane_wdata(in_size, readData2IN);
    end

    load_extender u_load_extender (
        .rdata_i (rdata_q),
        .lane_i  (alu_q[1:0]),
        .op_i    (op_q),
        .ext_o   (ext_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        cap_c      = 1'b0;
        ack_cap_c  = 1'b0;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        addr_c     = '0;
        cmd_c      = '0;
        wb_load_c  = 1'b0;
        wb_regwr_d = 1'b0;
        wb_m2r_d   = 1'b0;
        wb_rdata_d = '0;
        wb_alu_d   = '0;
        wb_dest_d  = '0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wb_load_c  = 1'b1;
                wb_regwr_d = RegWriteIN;
                wb_m2r_d   = MemtoRegIN;
                wb_alu_d   = ALU_IN;
                wb_dest_d  = DestinoIN;
                if (in_access && in_mis) begin
                    addr_err_d = 1'b1;
                    wb_regwr_d = 1'b0;
                end else if (in_access) begin
                    wb_load_c = 1'b0;
                    req_c     = 1'b1;
                    stall_c   = 1'b1;
                    addr_c    = ALU_IN[31:2];
                    cmd_c     = in_cmd;
                    cap_c     = 1'b1;
                    cnt_d     = '0;
                    tmo_d     = 1'b0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                addr_c  = alu_q[31:2];
                cmd_c   = cmd_q;
                cnt_d   = cnt_q + CNT_W'(1);
                // An ack landing on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    ack_cap_c = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_err_d = 1'b1;
                    tmo_d     = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_load_c  = 1'b1;
                wb_regwr_d = regwr_q & ~tmo_q;
                wb_m2r_d   = m2r_q;
                wb_alu_d   = alu_q;
                wb_dest_d  = dest_q;
                wb_rdata_d = (cmd_q.we || tmo_q) ? 32'd0 : ext_c;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Copy of the instruction taken at launch, plus the read data taken on ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q   <= '0;
            alu_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            regwr_q <= 1'b0;
            m2r_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (cap_c) begin
                cmd_q   <= cmd_c;
                alu_q   <= ALU_IN;
                op_q    <= tipoLoadIN;
                dest_q  <= DestinoIN;
                regwr_q <= RegWriteIN;
                m2r_q   <= MemtoRegIN;
            end
            if (ack_cap_c) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // MEM/WB register: loads on every unstalled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_regwr_q <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_dest_q  <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
            if (wb_load_c) begin
                wb_regwr_q <= wb_regwr_d;
                wb_m2r_q   <= wb_m2r_d;
                wb_rdata_q <= wb_rdata_d;
                wb_alu_q   <= wb_alu_d;
                wb_dest_q  <= wb_dest_d;
            end
        end
    end

    // Request side is combinational, so reset gates it directly.
    assign mem_req   = req_c & ~reset;
    assign mem_we    = cmd_c.we & ~reset;
    assign mem_addr  = reset ? 30'd0 : addr_c;
    assign mem_be    = reset ? 4'd0 : cmd_c.be;
    assign mem_wdata = reset ? 32'd0 : cmd_c.wdata;
    assign stall     = stall_c & ~reset;

    assign RegWriteOUT = wb_regwr_q;
    assign MemtoRegOUT = wb_m2r_q;
    assign ReadDataOUT = wb_rdata_q;
    assign ALU_OUT     = wb_alu_q;
    assign DestinoOUT  = wb_dest_q;
    assign addr_err    = addr_err_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random load/store/ALU traffic
// checked against a byte-level reference model.
module tb_mem_access_stage;

    localparam int unsigned TMO = 4;

    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_SB  = 6'b101000;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadIN, MemWriteIN, MemtoRegIN, RegWriteIN;
    logic [31:0] ALU_IN, readData2IN;
    logic [4:0]  DestinoIN;
    logic [5:0]  tipoLoadIN;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack, stall;
    logic        RegWriteOUT, MemtoRegOUT;
    logic [31:0] ReadDataOUT, ALU_OUT;
    logic [4:0]  DestinoOUT;
    logic        addr_err, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] load_ops  [5] = '{T_LB, T_LH, T_LW, T_LBU, T_LHU};
    logic [5:0] store_ops [3] = '{T_SB, T_SH, T_SW};

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .MemReadIN(MemReadIN), .MemWriteIN(MemWriteIN),
        .MemtoRegIN(MemtoRegIN), .RegWriteIN(RegWriteIN),
        .ALU_IN(ALU_IN), .readData2IN(readData2IN),
        .DestinoIN(DestinoIN), .tipoLoadIN(tipoLoadIN),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .RegWriteOUT(RegWriteOUT), .MemtoRegOUT(MemtoRegOUT),
        .ReadDataOUT(ReadDataOUT), .ALU_OUT(ALU_OUT), .DestinoOUT(DestinoOUT),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_bytes(input logic [5:0] op);
        case (op)
            T_LB, T_LBU, T_SB: return 1;
            T_LH, T_LHU, T_SH: return 2;
            default:           return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_mask(input int n);
        return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    // Little-endian slice at the lane, then extend by opcode signedness.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input int lane, input logic [31:0] rdat);
        int n;
        logic [31:0] v, m;
        n = ref_bytes(op);
        m = ref_mask(n);
        v = (rdat >> (8 * lane)) & m;
        if ((op == T_LB || op == T_LH) && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic clear_inputs();
        MemReadIN = 1'b0; MemWriteIN = 1'b0; MemtoRegIN = 1'b0; RegWriteIN = 1'b0;
        ALU_IN = '0; readData2IN = '0; DestinoIN = '0; tipoLoadIN = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Presents one instruction (entered #1 after a posedge) and follows it to writeback.
    // ack_k: BUSY cycle index carrying the ack; ack_k >= TMO means no ack.
    task automatic run_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                          input logic [5:0] op, input int ack_k, input logic [31:0] rdat);
        int n, lane;
        bit acc, mis, tmo;
        logic [31:0] exp_wd, exp_rd, rep;
        logic [3:0]  exp_be;
        n      = ref_bytes(op);
        lane   = int'(alu[1:0]);
        acc    = rd || wr;
        mis    = acc && ((lane % n) != 0);
        rep    = (n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'd1;
        exp_wd = (wd & ref_mask(n)) * rep;
        exp_be = 4'(((1 << n) - 1) << lane);
        tmo    = 1'b0;
        MemReadIN = rd; MemWriteIN = wr; MemtoRegIN = m2r; RegWriteIN = rw;
        ALU_IN = alu; readData2IN = wd; DestinoIN = dst; tipoLoadIN = op;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        if (acc && !mis) begin
            check("idle_req", 32'(mem_req), 32'd1);
            check("idle_stall", 32'(stall), 32'd1);
            check("idle_we", 32'(mem_we), 32'(wr));
            check("idle_addr", 32'(mem_addr), 32'(alu[31:2]));
            check("idle_be", 32'(mem_be), 32'(exp_be));
            check("idle_wdata", mem_wdata, wr ? exp_wd : mem_wdata);
            tmo = 1'b1;
            for (int k = 0; k < int'(TMO); k++) begin
                @(posedge clk); #1;
                mem_ack   = (k == ack_k);
                mem_rdata = (k == ack_k) ? rdat : $urandom;
                @(negedge clk);
                check("busy_req", 32'(mem_req), 32'd1);
                check("busy_stall", 32'(stall), 32'd1);
                check("busy_we", 32'(mem_we), 32'(wr));
                check("busy_addr", 32'(mem_addr), 32'(alu[31:2]));
                check("busy_be", 32'(mem_be), 32'(exp_be));
                check("busy_bus_err", 32'(bus_err), 32'd0);
                if (k == ack_k) begin
                    tmo = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
            check("done_stall", 32'(stall), 32'd0);
            check("done_req", 32'(mem_req), 32'd0);
            check("done_bus_err", 32'(bus_err), 32'(tmo));
            @(posedge clk); #1;
            exp_rd = (wr || tmo) ? 32'd0 : ref_load(op, lane, rdat);
            check("wb_regwr", 32'(RegWriteOUT), 32'(rw && !tmo));
            check("wb_rdata", ReadDataOUT, exp_rd);
            check("wb_addr_err", 32'(addr_err), 32'd0);
            check("wb_bus_err", 32'(bus_err), 32'd0);
        end else begin
            check("pass_req", 32'(mem_req), 32'd0);
            check("pass_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            check("wb_regwr", 32'(RegWriteOUT), 32'(rw && !mis));
            check("wb_rdata", ReadDataOUT, 32'd0);
            check("wb_addr_err", 32'(addr_err), 32'(mis));
            check("wb_bus_err", 32'(bus_err), 32'd0);
        end
        check("wb_m2r", 32'(MemtoRegOUT), 32'(m2r));
        check("wb_alu", ALU_OUT, alu);
        check("wb_dest", 32'(DestinoOUT), 32'(dst));
        mem_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_regwr"}, 32'(RegWriteOUT), 32'd0);
        check({tag, "_m2r"}, 32'(MemtoRegOUT), 32'd0);
        check({tag, "_rdata"}, ReadDataOUT, 32'd0);
        check({tag, "_alu"}, ALU_OUT, 32'd0);
        check({tag, "_dest"}, 32'(DestinoOUT), 32'd0);
        check({tag, "_errs"}, 32'({addr_err, bus_err}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] alu;
        int          kind;
        clear_inputs();
        reset = 1'b1;
        MemReadIN = 1'b1; ALU_IN = 32'h0000_0040; tipoLoadIN = T_LW;
        #12;
        check_all_zero("rst");
        clear_inputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_op(1, 0, 1, 1, 32'h0000_0010, 32'h0, 5'd3, T_LW, 1, 32'hDEAD_BEEF);
        check("tp_lw_data", ReadDataOUT, 32'hDEAD_BEEF);
        check("tp_lw_regwr", 32'(RegWriteOUT), 32'd1);
        run_op(1, 0, 1, 1, 32'h0000_0013, 32'h0, 5'd4, T_LB, 0, 32'h80FF_0000);
        check("tp_lb", ReadDataOUT, 32'hFFFF_FF80);
        run_op(1, 0, 1, 1, 32'h0000_0013, 32'h0, 5'd4, T_LBU, 0, 32'h80FF_0000);
        check("tp_lbu", ReadDataOUT, 32'h0000_0080);
        run_op(1, 0, 1, 1, 32'h0000_0012, 32'h0, 5'd5, T_LH, 2, 32'h80FF_0000);
        check("tp_lh", ReadDataOUT, 32'hFFFF_80FF);
        run_op(0, 1, 0, 0, 32'h0000_0006, 32'h0000_1234, 5'd0, T_SH, 0, 32'h0);
        run_op(1, 0, 1, 1, 32'h0000_0002, 32'h0, 5'd6, T_LW, 0, 32'h0);
        check("tp_mis_addr_err", 32'(addr_err), 32'd1);
        run_op(1, 0, 0, 0, 32'h0000_0100, 32'h0, 5'd1, T_LW, 0, 32'h1111_2222);
        check("tp_mis_pulse", 32'(addr_err), 32'd0);
        run_op(1, 0, 1, 1, 32'h0000_0020, 32'h0, 5'd7, T_LW, int'(TMO), 32'h0);
        run_op(1, 0, 1, 1, 32'h0000_0024, 32'h0, 5'd8, T_LHU, int'(TMO) - 1, 32'h1234_ABCD);
        run_op(0, 0, 1, 1, 32'hCAFE_F00D, 32'h5555_AAAA, 5'd9, T_LW, 0, 32'h0);
        run_op(1, 1, 0, 1, 32'h0000_0031, 32'hA5A5_00C3, 5'd10, T_SB, 0, 32'hFFFF_FFFF);

        // Reset while a load is outstanding.
        MemReadIN = 1'b1; RegWriteIN = 1'b1; ALU_IN = 32'h0000_0044; tipoLoadIN = T_LW; DestinoIN = 5'd11;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy_req", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1 check_all_zero("rst_mid");
        clear_inputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(1, 0, 1, 1, 32'h0000_0048, 32'h0, 5'd12, T_LW, 0, 32'h0BAD_F00D);
        check("rst_after_load", ReadDataOUT, 32'h0BAD_F00D);

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            alu  = $urandom;
            if ($urandom_range(0, 2) == 0) alu[1:0] = 2'b00;
            if (kind < 2) begin
                op = load_ops[$urandom_range(0, 4)];
                run_op(0, 0, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), op, 0, 32'h0);
            end else if (kind < 6) begin
                op = load_ops[$urandom_range(0, 4)];
                run_op(1, 0, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), op,
                       $urandom_range(0, TMO), $urandom);
            end else begin
                op = store_ops[$urandom_range(0, 2)];
                run_op(kind == 9, 1, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), op,
                       $urandom_range(0, TMO), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
